// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and size decode for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // Zero mask marks the reserved codes (3, 6, 7).
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: size_mask = 4'h1;
      F3_LH, F3_LHU: size_mask = 4'h3;
      F3_LW:         size_mask = 4'hF;
      default:       size_mask = 4'h0;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] funct3);
    f3_legal = (size_mask(funct3) != 4'h0);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane mask/data placement and load extraction with extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [7:0]  m64_o,
  output logic [63:0] d64_o,
  output logic        split_o,
  output logic [31:0] ld_data_o
);

  logic [63:0] shifted;

  assign m64_o   = {4'h0, size_mask(funct3_i)} << off_i;
  assign d64_o   = {32'h0, wdata_i} << {off_i, 3'b000};
  assign split_o = |m64_o[7:4];
  assign shifted = {hi_i, lo_i} >> {off_i, 3'b000};

  always_comb begin
    ld_data_o = '0;
    case (funct3_i)
      F3_LB:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   ld_data_o = shifted[31:0];
      F3_LBU:  ld_data_o = {24'h0, shifted[7:0]};
      F3_LHU:  ld_data_o = {16'h0, shifted[15:0]};
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit splitting byte-addressed accesses into one or two word cycles
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  lsu_state_e        state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_q;

  logic [7:0]        m64;
  logic [63:0]       d64;
  logic              split;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-3:0] word0;
  logic [ADDR_W-3:0] word1;

  lsu_align u_align (
    .funct3_i  (funct3_q),
    .off_i     (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .lo_i      (lo_q),
    .hi_i      (hi_q),
    .m64_o     (m64),
    .d64_o     (d64),
    .split_o   (split),
    .ld_data_o (ld_data)
  );

  // Word index wraps at the top of the word space for the second half.
  assign word0 = addr_q[ADDR_W-1:2];
  assign word1 = word0 + 1'b1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            we_q     <= i_req_we;
            funct3_q <= i_req_funct3;
            addr_q   <= i_req_addr;
            wdata_q  <= i_req_wdata;
            lo_q     <= '0;
            hi_q     <= '0;
            state_q  <= f3_legal(i_req_funct3) ? ACC0 : RESP;
          end
        end
        ACC0: begin
          if (!we_q) lo_q <= i_mem_rdata;
          state_q <= split ? ACC1 : RESP;
        end
        ACC1: begin
          if (!we_q) hi_q <= i_mem_rdata;
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    o_mem_wren  = 1'b0;
    case (state_q)
      ACC0: begin
        o_mem_addr  = {2'b00, word0};
        o_mem_wdata = d64[31:0];
        o_mem_bmask = m64[3:0];
        o_mem_wren  = we_q;
      end
      ACC1: begin
        o_mem_addr  = {2'b00, word1};
        o_mem_wdata = d64[63:32];
        o_mem_bmask = m64[7:4];
        o_mem_wren  = we_q;
      end
      default: ;
    endcase
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_err   = (state_q == RESP) && !f3_legal(funct3_q);
  assign o_rsp_rdata = ((state_q == RESP) && !we_q && f3_legal(funct3_q)) ? ld_data : '0;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized and directed checks of lsu against a byte-level memory model
module tb_lsu;

  logic        i_clk;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        o_mem_wren;
  logic [31:0] i_mem_rdata;

  lsu dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_bmask  (o_mem_bmask),
    .o_mem_wren   (o_mem_wren),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Word memory seen by the DUT (64 words, index taken modulo 64) and a byte-level model of it.
  logic [31:0] mem_w [64];
  logic [7:0]  sh [256];
  logic        init_req;

  always @(posedge i_clk) begin
    if (init_req) begin
      for (int w = 0; w < 64; w++)
        mem_w[w] <= {sh[4*w+3], sh[4*w+2], sh[4*w+1], sh[4*w]};
    end else if (o_mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_bmask[b]) mem_w[o_mem_addr[5:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
  end

  assign i_mem_rdata = mem_w[o_mem_addr[5:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f);
    if (f[1:0] == 2'd0) return 1;
    if (f[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic is_legal(input logic [2:0] f);
    return !(f == 3'd3 || f == 3'd6 || f == 3'd7);
  endfunction

  function automatic logic [31:0] model_word(input int w);
    return {sh[4*w+3], sh[4*w+2], sh[4*w+1], sh[4*w]};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] v;
    int n;
    v = '0;
    n = acc_size(f);
    for (int i = 0; i < n; i++) v[8*i +: 8] = sh[8'(a + 32'(i))];
    if (!f[2] && n == 1 && v[7])  v[31:8]  = '1;
    if (!f[2] && n == 2 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  logic [31:0] last_rd;
  int          last_lat;
  logic [31:0] last_acc_a [2];
  logic [3:0]  last_acc_m [2];
  logic [31:0] last_acc_d [2];

  task automatic do_op(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    int          n, off, pos, nacc, lat, exp_lat, exp_nacc, w0;
    logic        lg, got_v, stray, er;
    logic [31:0] rd, exp_rd;
    logic [31:0] acc_a [2];
    logic [3:0]  acc_m [2];
    logic [31:0] acc_d [2];
    logic        acc_w [2];
    logic [3:0]  em [2];
    logic [31:0] ed [2];
    logic [31:0] ea [2];

    n   = acc_size(f);
    off = int'(a[1:0]);
    lg  = is_legal(f);
    exp_lat  = !lg ? 1 : (off + n > 4) ? 3 : 2;
    exp_nacc = !lg ? 0 : (off + n > 4) ? 2 : 1;
    ea[0] = a >> 2;
    ea[1] = ((a >> 2) + 32'd1) & 32'h3FFF_FFFF;
    em[0] = '0; em[1] = '0; ed[0] = '0; ed[1] = '0;
    for (int i = 0; i < n; i++) begin
      pos = off + i;
      if (pos < 4) begin
        em[0][pos] = 1'b1;
        ed[0][8*pos +: 8] = wd[8*i +: 8];
      end else begin
        em[1][pos-4] = 1'b1;
        ed[1][8*(pos-4) +: 8] = wd[8*i +: 8];
      end
    end
    exp_rd = (we || !lg) ? 32'h0 : model_load(a, f);

    @(negedge i_clk);
    check("req_ready", 32'(o_req_ready), 32'd1);
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f;
    i_req_addr   = a;
    i_req_wdata  = wd;
    @(posedge i_clk);

    nacc = 0; lat = 0; got_v = 1'b0; stray = 1'b0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 6 && !got_v; k++) begin
      @(negedge i_clk);
      i_req_valid  = 1'b0;
      i_req_addr   = $urandom;
      i_req_funct3 = 3'($urandom_range(0, 7));
      if (o_mem_wren && (o_mem_bmask == 4'h0 || o_rsp_valid)) stray = 1'b1;
      if (o_rsp_valid) begin
        got_v = 1'b1;
        lat   = k;
        rd    = o_rsp_rdata;
        er    = o_rsp_err;
        check("resp_mem_addr", o_mem_addr, 32'h0);
      end else if (o_mem_bmask != 4'h0 && nacc < 2) begin
        acc_a[nacc] = o_mem_addr;
        acc_m[nacc] = o_mem_bmask;
        acc_d[nacc] = o_mem_wdata;
        acc_w[nacc] = o_mem_wren;
        nacc++;
      end
    end

    check("rsp_seen", 32'(got_v), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_err", 32'(er), 32'(!lg));
    check("rsp_rdata", rd, exp_rd);
    check("acc_count", 32'(nacc), 32'(exp_nacc));
    check("wren_stray", 32'(stray), 32'd0);
    for (int j = 0; j < nacc && j < exp_nacc; j++) begin
      check("acc_addr", acc_a[j], ea[j]);
      check("acc_bmask", 32'(acc_m[j]), 32'(em[j]));
      check("acc_wren", 32'(acc_w[j]), 32'(we));
      if (we) check("acc_wdata", acc_d[j] & lanes(em[j]), ed[j]);
      last_acc_a[j] = acc_a[j];
      last_acc_m[j] = acc_m[j];
      last_acc_d[j] = acc_d[j];
    end

    if (we && lg)
      for (int i = 0; i < n; i++) sh[8'(a + 32'(i))] = wd[8*i +: 8];
    w0 = int'((a >> 2) & 32'd63);
    check("mem_word0", mem_w[w0], model_word(w0));
    check("mem_word1", mem_w[(w0 + 1) % 64], model_word((w0 + 1) % 64));

    last_rd  = rd;
    last_lat = lat;
  endtask

  initial begin
    i_reset      = 1'b1;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_funct3 = '0;
    i_req_addr   = '0;
    i_req_wdata  = '0;
    init_req     = 1'b1;
    for (int i = 0; i < 256; i++) sh[i] = 8'($urandom);
    {sh[19], sh[18], sh[17], sh[16]} = 32'h1122_3344;
    {sh[23], sh[22], sh[21], sh[20]} = 32'hAABB_CCDD;

    repeat (3) @(negedge i_clk);
    init_req = 1'b0;
    check("rst_ready", 32'(o_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'h0);
    check("rst_mem_wdata", o_mem_wdata, 32'h0);
    check("rst_mem_bmask", 32'(o_mem_bmask), 32'd0);
    check("rst_mem_wren", 32'(o_mem_wren), 32'd0);
    i_reset = 1'b0;

    do_op(1'b0, 3'd2, 32'h10, 32'h0);
    check("t1_rdata", last_rd, 32'h1122_3344);
    check("t1_addr", last_acc_a[0], 32'd4);
    do_op(1'b0, 3'd0, 32'h13, 32'h0);
    check("t2_lb13", last_rd, 32'h0000_0011);
    do_op(1'b0, 3'd0, 32'h17, 32'h0);
    check("t2_lb17", last_rd, 32'hFFFF_FFAA);
    do_op(1'b0, 3'd4, 32'h17, 32'h0);
    check("t2_lbu17", last_rd, 32'h0000_00AA);
    do_op(1'b0, 3'd1, 32'h16, 32'h0);
    check("t2_lh16", last_rd, 32'hFFFF_AABB);
    do_op(1'b0, 3'd2, 32'h12, 32'h0);
    check("t3_rdata", last_rd, 32'hCCDD_1122);
    check("t3_lat", 32'(last_lat), 32'd3);
    check("t3_addr1", last_acc_a[1], 32'd5);
    do_op(1'b1, 3'd1, 32'h13, 32'h0000_BEEF);
    check("t4_mask0", 32'(last_acc_m[0]), 32'h8);
    check("t4_wdata0", last_acc_d[0], 32'hEF00_0000);
    check("t4_mask1", 32'(last_acc_m[1]), 32'h1);
    check("t4_wdata1", last_acc_d[1], 32'h0000_00BE);
    check("t4_word4", mem_w[4], 32'hEF22_3344);
    check("t4_word5", mem_w[5], 32'hAABB_CCBE);
    do_op(1'b0, 3'd3, 32'h10, 32'h0);
    check("t5_lat", 32'(last_lat), 32'd1);
    do_op(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0);
    check("wrap_addr1", last_acc_a[1], 32'h0);

    // Reset during the second half of a split store.
    @(negedge i_clk);
    check("t6_ready", 32'(o_req_ready), 32'd1);
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_funct3 = 3'd2;
    i_req_addr   = 32'h1E;
    i_req_wdata  = 32'hCAFE_F00D;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    check("t6_acc0_wren", 32'(o_mem_wren), 32'd1);
    @(negedge i_clk);
    check("t6_acc1_wren", 32'(o_mem_wren), 32'd1);
    check("t6_acc1_addr", o_mem_addr, 32'd8);
    i_reset = 1'b1;
    #1;
    check("t6_wren_drop", 32'(o_mem_wren), 32'd0);
    check("t6_bmask_drop", 32'(o_mem_bmask), 32'd0);
    check("t6_no_rsp", 32'(o_rsp_valid), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    sh[8'h1E] = 8'h0D;
    sh[8'h1F] = 8'hF0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("t6_no_rsp_after", 32'(o_rsp_valid), 32'd0);
    end
    check("t6_ready_after", 32'(o_req_ready), 32'd1);
    check("t6_word8", mem_w[8], model_word(8));
    check("t6_word7", mem_w[7], model_word(7));
    check("t6_word7_hi", 32'(mem_w[7][31:16]), 32'hF00D);

    for (int t = 0; t < 300; t++)
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit that issues word-granular requests into the single-port data `memory` and returns aligned, extended load data to the pipeline. It converts one byte-addressed RV32 access (LB/LH/LW/LBU/LHU/SB/SH/SW) into one or two memory word cycles. It generates the word address, byte mask, shifted write data and write enable, and performs sign or zero extension on loads. It sits between the execute/MEM stage and `memory`, and acts as the initiator of the memory's addr/wdata/bmask/wren/rdata interface.

## Interface
- ADDR_W, 32, byte-address width of requests and width of `o_mem_addr`.
- DATA_W, 32, data width; fixed at 32, with a 4-bit byte mask.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset; asynchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  high only in IDLE; a request is accepted on the edge where valid and ready are both high.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  RV32 funct3 size/sign code.
- i_req_addr  in  ADDR_W  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  illegal funct3; valid together with `o_rsp_valid`.
- o_mem_addr  out  ADDR_W  word index, equal to the byte address >> 2, zero-extended.
- o_mem_wdata  out  32  lane-shifted write data.
- o_mem_bmask  out  4  byte-lane enables.
- o_mem_wren  out  1  write strobe.
- i_mem_rdata  in  32  word read at `o_mem_addr`, combinational in the same cycle.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- On accept, register the op, funct3, byte address and wdata.
  - Legal funct3 → ACC0.
  - Illegal funct3 (3, 6, 7) → RESP with err = 1 and no memory cycle.
- Size mask: 0x1 for B/BU, 0x3 for H/HU, 0xF for W. Lane offset `off` = addr[1:0].
- Combined mask: m64 = size_mask << off, 8 bits wide. Combined data: d64 = wdata << (8*off), 64 bits wide.
- Split condition: m64[7:4] ≠ 0, i.e. the access crosses a word boundary.
- ACC0:
  - Drive addr = A>>2, bmask = m64[3:0], wdata = d64[31:0].
  - `wren` = store.
  - Loads latch `i_mem_rdata` into `lo`.
  - Next state is ACC1 if split, else RESP.
- ACC1:
  - Drive addr = (A>>2)+1, taken modulo 2^(ADDR_W-2) so the top word wraps to 0.
  - bmask = m64[7:4], wdata = d64[63:32].
  - Loads latch `i_mem_rdata` into `hi`.
  - Next state is RESP.
- RESP:
  - `o_rsp_valid` = 1.
  - For loads, rdata = ({hi,lo} >> 8*off), truncated to the access size, then sign-extended (LB/LH) or zero-extended (LBU/LHU/LW). `hi` is treated as 0 when the access is not split.
  - Next state is IDLE.
- Outside ACC0/ACC1, drive `o_mem_wren` = 0, `o_mem_bmask` = 0, `o_mem_wdata` = 0 and `o_mem_addr` = 0.
- In ACC0/ACC1, `o_mem_bmask` is driven with the lane mask for loads too, but `o_mem_wren` stays 0.
- Requests arriving while busy are ignored; `i_req_valid` must be held until accepted.

## Timing
- Accept edge E0. Latency to the `o_rsp_valid` cycle, counted in cycles after E0:
  - Illegal funct3: 1.
  - Aligned access: 2.
  - Split access: 3.
- `o_req_ready` returns high the cycle after RESP. Peak throughput is one aligned access per 3 cycles.
- All `o_mem_*` outputs are decoded from registered state only. They never depend combinationally on `i_req_*`.
- Reset values: state = IDLE and `o_req_ready` = 1. All other outputs are 0, and `lo`/`hi` = 0.
- Reset asserted mid-operation:
  - Outputs drop asynchronously, including `wren`.
  - No response is produced.
  - An ACC0 half-write that already completed for a split store is not rolled back.

## Structure
- `lsu_pkg` contains:
  - The state enum.
  - The funct3 localparams: LB = 0, LH = 1, LW = 2, LBU = 4, LHU = 5; SB/SH/SW = 0/1/2.
  - A `size_mask(funct3)` function.
- Sub-module `lsu_align` is purely combinational. It computes m64/d64 and the load extraction/extension.
- `lsu` itself holds the FSM and the request, `lo` and `hi` registers.

## Test plan
Preload `memory` with word 4 = 0x11223344 and word 5 = 0xAABBCCDD.
1. LW at 0x10 → rdata 0x11223344, with `o_rsp_valid` 2 cycles after accept. `o_mem_addr` = 4 in ACC0; `wren` never goes high.
2. Byte loads:
   - LB at 0x13 → 0x00000011.
   - LB at 0x17 → 0xFFFFFFAA.
   - LBU at 0x17 → 0x000000AA.
   - LH at 0x16 → 0xFFFFAABB.
3. LW at 0x12 (split) → `o_mem_addr` 4 then 5; rdata 0xCCDD1122 with latency 3.
4. SH at 0x13 with wdata 0x0000BEEF:
   - ACC0: addr 4, bmask 0b1000, wdata 0xEF000000.
   - ACC1: addr 5, bmask 0b0001, wdata 0x000000BE.
   - Resulting memory: word 4 = 0x11223344 with byte 3 = 0xEF, i.e. 0xEF223344; word 5 = 0xAABBCCBE.
5. funct3 = 3 → `o_rsp_err` = 1 and rdata 0 after 1 cycle; no `wren` and no bmask activity.
6. i_reset during ACC1 of SW at 0x1E (split) → `wren` drops immediately and no `o_rsp_valid` is produced. After release `o_req_ready` = 1 and word 8 is unchanged; word 7 upper half is written.
